// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS address controller.
package dds_pkg;

    localparam int unsigned PHASE_W_DEF = 32;
    localparam int unsigned LUT_AW_DEF  = 10;
    localparam int unsigned BURST_W_DEF = 16;

    typedef logic [1:0] dds_state_t;

    localparam dds_state_t StIdle     = 2'd0;
    localparam dds_state_t StRun      = 2'd1;
    localparam dds_state_t StStopPend = 2'd2;

    // Increment that advances the ROM address by exactly one entry per clock.
    localparam logic [PHASE_W_DEF-1:0] FWORD_UNIT =
        {{(PHASE_W_DEF-1){1'b0}}, 1'b1} << (PHASE_W_DEF - LUT_AW_DEF);

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with wrap detect, active/pending frequency words and table index.
// QUARTER_WAVE_EN selects quarter-wave indexing with a sign output.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned LUT_AW  = LUT_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               clear_i,
    input  logic               idle_i,
    input  logic               cfg_accept_i,
    input  logic [PHASE_W-1:0] cfg_fword_i,
    output logic               wrap_o,
    output logic               pend_full_o,
    output logic [LUT_AW-1:0]  idx_o,
    output logic               sign_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] act_q, act_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [PHASE_W:0]   sum;
    logic               direct;

    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, act_q};
        wrap_o  = run_i & sum[PHASE_W];
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (run_i) begin
            phase_d = sum[PHASE_W-1:0];
        end
    end

    // A zero increment never wraps, so words must land directly or a stop would never finish.
    assign direct = idle_i || (act_q == '0);

    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (direct) begin
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end else if (cfg_accept_i) begin
                act_d = cfg_fword_i;
            end
        end else begin
            if (wrap_o && pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end
            if (cfg_accept_i) begin
                pend_d      = cfg_fword_i;
                pend_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign pend_full_o = pend_full_q;

`ifdef QUARTER_WAVE_EN
    logic [LUT_AW-1:0] quarter;

    always_comb begin
        quarter = phase_q[PHASE_W-3 -: LUT_AW];
        idx_o   = phase_q[PHASE_W-2] ? ~quarter : quarter;
        sign_o  = phase_q[PHASE_W-1];
    end
`else
    always_comb begin
        idx_o  = phase_q[PHASE_W-1 -: LUT_AW];
        sign_o = 1'b0;
    end
`endif

endmodule

// File: rtl/dds_addr_ctrl.sv
// Sine ROM address sequencer: start/stop/burst FSM and ROM-latency output alignment.
// QUARTER_WAVE_EN (see dds_phase_acc) switches to quarter-wave addressing with neg_o.
module dds_addr_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned LUT_AW  = LUT_AW_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               cfg_valid_i,
    input  logic [PHASE_W-1:0] cfg_fword_i,
    output logic               cfg_ready_o,
    output logic [LUT_AW:0]    rom_addr_o,
    output logic               addr_vld_o,
    output logic               data_vld_o,
    output logic               neg_o,
    output logic               period_done_o,
    output logic               busy_o
);

    dds_state_t         state_q, state_d;
    logic [BURST_W-1:0] burst_len_q, burst_len_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [BURST_W:0]   cnt_next;
    logic               wrap, last_wrap, pend_full, cfg_accept;
    logic               running;
    logic [LUT_AW-1:0]  idx;
    logic               sign;

    logic [LUT_AW:0]    rom_addr_q;
    logic               addr_vld_q, data_vld_q, period_done_q;
    logic               sign_q, neg_q;

    assign running    = (state_q != StIdle);
    assign cfg_accept = cfg_valid_i && !pend_full;

    dds_phase_acc #(
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW)
    ) u_phase_acc (
        .clk          (clk),
        .rst          (rst),
        .run_i        (running),
        .clear_i      (state_d == StIdle),
        .idle_i       (!running),
        .cfg_accept_i (cfg_accept),
        .cfg_fword_i  (cfg_fword_i),
        .wrap_o       (wrap),
        .pend_full_o  (pend_full),
        .idx_o        (idx),
        .sign_o       (sign)
    );

    always_comb begin
        cnt_next  = {1'b0, burst_cnt_q} + 1'b1;
        last_wrap = wrap && (burst_len_q != '0) && (cnt_next == {1'b0, burst_len_q});

        state_d     = state_q;
        burst_len_d = burst_len_q;
        burst_cnt_d = burst_cnt_q;
        if (wrap) begin
            burst_cnt_d = cnt_next[BURST_W-1:0];
        end

        case (state_q)
            StIdle: begin
                // start outranks a simultaneous stop
                if (start_i) begin
                    state_d     = StRun;
                    burst_len_d = burst_len_i;
                    burst_cnt_d = '0;
                end
            end
            StRun: begin
                if (last_wrap) begin
                    state_d = StIdle;
                end else if (stop_i) begin
                    state_d = StStopPend;
                end
            end
            StStopPend: begin
                if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            burst_len_q   <= '0;
            burst_cnt_q   <= '0;
            rom_addr_q    <= '0;
            addr_vld_q    <= 1'b0;
            data_vld_q    <= 1'b0;
            period_done_q <= 1'b0;
            sign_q        <= 1'b0;
            neg_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_len_q   <= burst_len_d;
            burst_cnt_q   <= burst_cnt_d;
            rom_addr_q    <= {1'b0, idx};
            addr_vld_q    <= running;
            data_vld_q    <= addr_vld_q;
            period_done_q <= wrap;
            // sign rides one stage behind the address so it lines up with ROM data
            sign_q        <= sign;
            neg_q         <= sign_q;
        end
    end

    assign cfg_ready_o   = !pend_full;
    assign rom_addr_o    = rom_addr_q;
    assign addr_vld_o    = addr_vld_q;
    assign data_vld_o    = data_vld_q;
    assign neg_o         = neg_q;
    assign period_done_o = period_done_q;
    assign busy_o        = running;

endmodule
